// File: rtl/hit_monitor_pkg.sv
// -----------------------------------------------------------------------------
// hit_monitor_pkg
// Shared definitions for the hit monitor: the FSM state encoding and its width.
// Imported by hit_monitor and sat_counter.
// -----------------------------------------------------------------------------
package hit_monitor_pkg;

  localparam int STATE_W = 2;

  // IDLE waits for start; RUN counts cycles; HIT and TMO are terminal.
  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2,
    TMO  = 2'd3
  } state_e;

endpackage : hit_monitor_pkg

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at its all-ones value instead of wrapping.
//
// Ports:
//   clk    in  1  clock, state on rising edge
//   reset  in  1  synchronous active-high reset, counter to 0
//   clr_i  in  1  synchronous clear, counter to 0 (wins over en_i)
//   en_i   in  1  count enable
//   cnt_o  out W  current count
// -----------------------------------------------------------------------------
module sat_counter
  import hit_monitor_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hit_monitor.sv
// -----------------------------------------------------------------------------
// hit_monitor
// Watches a set of upstream comparison flags during a bounded run. After start
// it counts RUN cycles; the first cycle z1 is high latches the cycle number
// into first_hit and ends in HIT, otherwise reaching TIMEOUT-1 ends in TMO.
// Cycles with z4 high are counted while running and after a hit.
//
// Optional feature: define HIT_MONITOR_VIOL_EN to build a sticky checker that
// flags inconsistent flag combinations (z2!=z3, z1&z3, z1&!z4) in RUN/HIT.
// Without it viol is tied to 0.
//
// Ports:
//   clk        in  1    clock, all state on rising edge
//   reset      in  1    synchronous active-high reset (highest priority)
//   start      in  1    begin a run, honoured in IDLE only
//   clr        in  1    synchronous soft clear to IDLE
//   z1..z4     in  1    upstream flags
//   state      out 2    current FSM state (registered)
//   cyc        out CW   RUN cycle count, saturating
//   first_hit  out CW   cyc value when z1 was first seen high
//   hit_cnt    out HCW  cycles with z4 high in RUN/HIT, saturating
//   done       out 1    state is HIT or TMO
//   viol       out 1    sticky consistency violation
// -----------------------------------------------------------------------------
module hit_monitor
  import hit_monitor_pkg::*;
#(
  parameter int CW      = 16,
  parameter int HCW     = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               clr,
  input  logic               z1,
  input  logic               z2,
  input  logic               z3,
  input  logic               z4,
  output logic [STATE_W-1:0] state,
  output logic [CW-1:0]      cyc,
  output logic [CW-1:0]      first_hit,
  output logic [HCW-1:0]     hit_cnt,
  output logic               done,
  output logic               viol
);

  // Last RUN cycle number before the run times out.
  localparam logic [CW-1:0] TMO_CYC = CW'(TIMEOUT - 1);

  state_e        state_q;
  logic [CW-1:0] first_hit_q;

  logic in_run;
  logic in_run_or_hit;

  assign in_run        = (state_q == RUN);
  assign in_run_or_hit = (state_q == RUN) || (state_q == HIT);

  // ---------------------------------------------------------------------------
  // Counters. Clearing cyc on an accepted start guarantees the run begins at 0.
  // ---------------------------------------------------------------------------
  sat_counter #(.W(CW)) u_cyc_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr || ((state_q == IDLE) && start)),
    .en_i  (in_run),
    .cnt_o (cyc)
  );

  sat_counter #(.W(HCW)) u_hit_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (clr),
    .en_i  (in_run_or_hit && z4),
    .cnt_o (hit_cnt)
  );

  // ---------------------------------------------------------------------------
  // Control FSM with first_hit capture. z1 is checked before the timeout so a
  // hit on the final cycle resolves to HIT.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state_q     <= IDLE;
      first_hit_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (z1) begin
            state_q     <= HIT;
            first_hit_q <= cyc;
          end else if (cyc == TMO_CYC) begin
            state_q <= TMO;
          end
        end
        HIT, TMO: begin
          state_q <= state_q;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign state     = state_q;
  assign first_hit = first_hit_q;
  assign done      = (state_q == HIT) || (state_q == TMO);

  // ---------------------------------------------------------------------------
  // Optional consistency checker
  // ---------------------------------------------------------------------------
`ifdef HIT_MONITOR_VIOL_EN
  logic viol_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      viol_q <= 1'b0;
    end else if (in_run_or_hit && ((z2 != z3) || (z1 && z3) || (z1 && !z4))) begin
      viol_q <= 1'b1;
    end
  end

  assign viol = viol_q;
`else
  // z2/z3 only feed the checker; fold them into a named sink when it is absent.
  logic unused_z;
  assign unused_z = z2 ^ z3;
  assign viol     = 1'b0;
`endif

endmodule : hit_monitor

// File: tb/tb_hit_monitor.sv
// -----------------------------------------------------------------------------
// tb_hit_monitor
// Directed bench for hit_monitor. u_dut uses TIMEOUT=10; u_dut_long shares its
// inputs with TIMEOUT=1000 so a 300-cycle run stays in RUN.
// -----------------------------------------------------------------------------
module tb_hit_monitor;
  import hit_monitor_pkg::*;

  localparam int CW  = 16;
  localparam int HCW = 8;

`ifdef HIT_MONITOR_VIOL_EN
  localparam logic VIOL_EN = 1'b1;
`else
  localparam logic VIOL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, start, clr, z1, z2, z3, z4;

  logic [STATE_W-1:0] state,     state_l;
  logic [CW-1:0]      cyc,       cyc_l;
  logic [CW-1:0]      first_hit, first_hit_l;
  logic [HCW-1:0]     hit_cnt,   hit_cnt_l;
  logic               done,      done_l;
  logic               viol,      viol_l;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hit_monitor #(.CW(CW), .HCW(HCW), .TIMEOUT(10)) u_dut (
    .clk(clk), .reset(reset), .start(start), .clr(clr),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4),
    .state(state), .cyc(cyc), .first_hit(first_hit),
    .hit_cnt(hit_cnt), .done(done), .viol(viol)
  );

  hit_monitor #(.CW(CW), .HCW(HCW), .TIMEOUT(1000)) u_dut_long (
    .clk(clk), .reset(reset), .start(start), .clr(clr),
    .z1(z1), .z2(z2), .z3(z3), .z4(z4),
    .state(state_l), .cyc(cyc_l), .first_hit(first_hit_l),
    .hit_cnt(hit_cnt_l), .done(done_l), .viol(viol_l)
  );

  typedef struct {
    logic               rst;
    logic               st_in;
    logic               clr_in;
    logic [3:0]         z;      // {z4, z3, z2, z1}
    logic [STATE_W-1:0] e_state;
    logic [CW-1:0]      e_cyc;
    logic [CW-1:0]      e_fh;
    logic [HCW-1:0]     e_hc;
    logic               e_done;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs on the falling edge, then sample 1ns after the
  // rising edge that registers them.
  task automatic step(input logic r, input logic s, input logic c, input logic [3:0] z);
    @(negedge clk);
    reset = r;
    start = s;
    clr   = c;
    {z4, z3, z2, z1} = z;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [STATE_W-1:0] e_st,
                           input logic [CW-1:0] e_cyc, input logic [CW-1:0] e_fh,
                           input logic [HCW-1:0] e_hc, input logic e_done);
    check({tag, ".state"},     32'(state),     32'(e_st));
    check({tag, ".cyc"},       32'(cyc),       32'(e_cyc));
    check({tag, ".first_hit"}, 32'(first_hit), 32'(e_fh));
    check({tag, ".hit_cnt"},   32'(hit_cnt),   32'(e_hc));
    check({tag, ".done"},      32'(done),      32'(e_done));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; clr = 1'b0;
    z1 = 1'b0; z2 = 1'b0; z3 = 1'b0; z4 = 1'b0;

    // Table: reset, ignored inputs in IDLE, run with z4 counting, hit at cyc=4,
    // start ignored in HIT, clr beating start, restart.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b0000, IDLE, 16'd0, 16'd0, 8'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 4'b0000, IDLE, 16'd0, 16'd0, 8'd0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'b1001, IDLE, 16'd0, 16'd0, 8'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 4'b0000, RUN,  16'd0, 16'd0, 8'd0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'b1000, RUN,  16'd1, 16'd0, 8'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'b0000, RUN,  16'd2, 16'd0, 8'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 4'b0000, RUN,  16'd3, 16'd0, 8'd1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 4'b1000, RUN,  16'd4, 16'd0, 8'd2, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b1001, HIT,  16'd5, 16'd4, 8'd3, 1'b1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 4'b1000, HIT,  16'd5, 16'd4, 8'd4, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 4'b0000, HIT,  16'd5, 16'd4, 8'd4, 1'b1};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 4'b1000, IDLE, 16'd0, 16'd0, 8'd0, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 4'b0000, RUN,  16'd0, 16'd0, 8'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst, vecs[i].st_in, vecs[i].clr_in, vecs[i].z);
      check_all($sformatf("vec%0d", i), vecs[i].e_state, vecs[i].e_cyc,
                vecs[i].e_fh, vecs[i].e_hc, vecs[i].e_done);
      check($sformatf("vec%0d.viol", i), 32'(viol), 32'(1'b0));
    end

    // Reset mid-run beats start and clr.
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    check("midrun.cyc", 32'(cyc), 32'd2);
    step(1'b1, 1'b1, 1'b1, 4'b0000);
    check_all("rst_midrun", IDLE, 16'd0, 16'd0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'b0000);

    // Timeout: z1 held low, TMO one cycle after cyc reaches 9.
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      check($sformatf("tmo.run%0d.state", k), 32'(state), 32'(RUN));
      check($sformatf("tmo.run%0d.cyc", k), 32'(cyc), 32'(k));
    end
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    check("tmo.state", 32'(state), 32'(TMO));
    check("tmo.first_hit", 32'(first_hit), 32'd0);
    check("tmo.done", 32'(done), 32'd1);
    // TMO is terminal: start ignored, z4 not counted.
    step(1'b0, 1'b1, 1'b0, 4'b1000);
    check("tmo.hold.state", 32'(state), 32'(TMO));
    check("tmo.hold.hit_cnt", 32'(hit_cnt), 32'd0);

    // Hit on the timeout cycle resolves to HIT.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    check("clr.state", 32'(state), 32'(IDLE));
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    for (int k = 1; k <= 9; k++) step(1'b0, 1'b0, 1'b0, 4'b0000);
    check("hit9.pre.cyc", 32'(cyc), 32'd9);
    step(1'b0, 1'b0, 1'b0, 4'b1001);
    check("hit9.state", 32'(state), 32'(HIT));
    check("hit9.first_hit", 32'(first_hit), 32'd9);
    check("hit9.done", 32'(done), 32'd1);

    // hit_cnt saturation: 300 RUN cycles with z4 high on the long instance.
    // The short instance counts only its 10 RUN cycles, then freezes in TMO.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 1'b0, 4'b1000);
    check("sat.long.state", 32'(state_l), 32'(RUN));
    check("sat.long.hit_cnt", 32'(hit_cnt_l), 32'd255);
    check("sat.long.cyc", 32'(cyc_l), 32'd300);
    check("sat.short.state", 32'(state), 32'(TMO));
    check("sat.short.hit_cnt", 32'(hit_cnt), 32'd10);

    // Violation checker: ignored in IDLE, sticky in RUN, cleared by clr.
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0010);
    check("viol.idle", 32'(viol), 32'd0);
    step(1'b0, 1'b1, 1'b0, 4'b0000);
    step(1'b0, 1'b0, 1'b0, 4'b0010);
    check("viol.set", 32'(viol), 32'(VIOL_EN));
    step(1'b0, 1'b0, 1'b0, 4'b0000);
    check("viol.sticky", 32'(viol), 32'(VIOL_EN));
    step(1'b0, 1'b0, 1'b0, 4'b0001);
    check("viol.z1_no_z4", 32'(viol), 32'(VIOL_EN));
    step(1'b0, 1'b0, 1'b1, 4'b0000);
    check("viol.clr", 32'(viol), 32'd0);
    check("viol.clr.state", 32'(state), 32'(IDLE));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_hit_monitor

// File: doc/hit_monitor.md
HIT_MONITOR -- requirements
Module: hit_monitor

Interface
REQ-001 SHALL have parameter CW, default 16: width of cycle counter and first_hit.
REQ-002 SHALL have parameter HCW, default 8: width of hit_cnt.
REQ-003 SHALL have parameter TIMEOUT, default 1000: RUN cycles allowed before timeout; legal range 1..2^CW-1.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  begin a monitoring run (honoured in IDLE only).
REQ-007 SHALL have port clr  in  1  synchronous soft clear to IDLE.
REQ-008 SHALL have ports z1, z2, z3, z4  in  1 each  upstream flags: x==200, x>200 (via !(x<=200)), x>200, x==200||y==200.
REQ-009 SHALL have port state  out  2  current FSM state.
REQ-010 SHALL have port cyc  out  CW  RUN cycle count.
REQ-011 SHALL have port first_hit  out  CW  cyc value when z1 first sampled high.
REQ-012 SHALL have port hit_cnt  out  HCW  count of cycles with z4 high.
REQ-013 SHALL have ports done  out  1  and viol  out  1  (terminal state reached; sticky consistency violation).

Function
REQ-014 SHALL implement states IDLE=0, RUN=1, HIT=2, TMO=3, registered.
REQ-015 IDLE: start=1 -> RUN next cycle with cyc=0; z inputs ignored.
REQ-016 RUN: cyc SHALL increment by 1 per cycle, saturating at 2^CW-1.
REQ-017 RUN, z1=1: next state HIT, first_hit <= current cyc.
REQ-018 RUN, z1=0 and cyc==TIMEOUT-1: next state TMO; first_hit unchanged (0).
REQ-019 z1 and timeout in the same cycle SHALL resolve to HIT.
REQ-020 HIT and TMO SHALL be terminal; cyc frozen; start ignored; exit only via clr or reset.
REQ-021 hit_cnt SHALL increment in RUN and HIT on each cycle z4=1, saturating at 2^HCW-1; frozen in IDLE and TMO.
REQ-022 done SHALL be 1 exactly when state is HIT or TMO (decode of registered state, zero added latency).
REQ-023 clr=1 in any state SHALL force IDLE and zero cyc, first_hit, hit_cnt, viol next cycle; clr wins over start and all other events.
REQ-024 All register updates SHALL take effect one cycle after the sampled inputs.

Reset
REQ-025 reset=1 SHALL, at the next rising edge, set state=IDLE, cyc=0, first_hit=0, hit_cnt=0, viol=0, done=0.
REQ-026 reset SHALL take priority over clr and start and SHALL abort a run mid-operation.

Configuration
REQ-027 With HIT_MONITOR_VIOL_EN defined, viol SHALL set (sticky) in RUN or HIT when z2!=z3, or z1&z3, or z1&!z4, cleared only by reset or clr.
REQ-028 Without HIT_MONITOR_VIOL_EN, viol SHALL be constant 0 and no checker logic SHALL be present.

Structure
REQ-029 A package hit_monitor_pkg SHALL hold the state enumeration and its 2-bit width constant.
REQ-030 A sub-module sat_counter (parameterised width, enable, synchronous clear, saturating) SHALL be used for cyc and hit_cnt.

Verification
REQ-031 reset 2 cycles, start=1 one cycle, z1=1 when cyc=4 -> state=HIT, first_hit=4, done=1 next cycle.
REQ-032 TIMEOUT=10, z1 held 0 -> state=TMO one cycle after cyc=9, first_hit=0, done=1.
REQ-033 TIMEOUT=10, z1=1 at cyc=9 -> state=HIT, first_hit=9.
REQ-034 HCW=8, z4 held 1 for 300 RUN cycles -> hit_cnt=255, no wrap.
REQ-035 macro defined, z2=1,z3=0 for one RUN cycle -> viol=1 next cycle, stays 1 after z2 drops; macro undefined -> viol=0.
REQ-036 in HIT, clr=1 and start=1 same cycle -> state=IDLE, cyc=first_hit=hit_cnt=0, viol=0; reset asserted mid-RUN -> IDLE next cycle.
